// File: rtl/muldiv_div_iter.sv
// Iterative mantissa divider: normalises subnormal operands, then runs radix-2 restoring division.
// Optional DIV_EARLY_TERM_EN: finish DIV as soon as the partial remainder reaches zero.
module muldiv_div_iter #(
  parameter int num_bits   = 16,
  parameter int exp_width  = 5,
  parameter int mant_width = 10,
  parameter int bias       = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        arithmetic,
  input  logic [mant_width-1:0]       mantA,
  input  logic [mant_width-1:0]       mantB,
  input  logic                        hidA,
  input  logic                        hidB,
  input  logic signed [exp_width+1:0] exp_a,
  input  logic signed [exp_width+1:0] exp_b,
  input  logic                        sign,
  input  logic [num_bits-1:0]         direct_result,
  input  logic                        zero,
  input  logic                        inf,
  input  logic                        subN,
  input  logic                        Norm,
  input  logic                        QNan,
  input  logic                        SNan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_bypass,
  output logic [num_bits-1:0]         out_direct,
  output logic [mant_width+2:0]       q_mant,
  output logic signed [exp_width+1:0] q_exp,
  output logic                        q_sign,
  output logic                        sticky,
  output logic                        out_zero,
  output logic                        out_inf,
  output logic                        out_subN,
  output logic                        out_Norm,
  output logic                        out_QNan,
  output logic                        out_SNan
);

  localparam int Q  = mant_width + 3;
  localparam int OW = mant_width + 1;
  localparam int RW = mant_width + 2;
  localparam int EW = exp_width + 2;
  localparam int CW = $clog2(Q + 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  if (bias != (2 ** (exp_width - 1)) - 1) begin : g_bias_check
    $error("muldiv_div_iter: bias does not match exp_width");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BYP  = 3'd1,
    NORM = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        dividend_q, dividend_d;
  logic [OW-1:0]        divisor_q, divisor_d;
  logic signed [EW-1:0] exp_a_q, exp_a_d;
  logic signed [EW-1:0] exp_b_q, exp_b_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [Q-1:0]         q_mant_q, q_mant_d;
  logic signed [EW-1:0] q_exp_q, q_exp_d;
  logic                 sticky_q, sticky_d;
  logic                 sign_q, sign_d;
  logic                 bypass_q, bypass_d;
  logic [num_bits-1:0]  direct_q, direct_d;
  logic [5:0]           flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;

  logic                 norm_done_s;
  logic                 div_ge_s;
  logic [RW-1:0]        div_diff_s;
  logic [RW-1:0]        div_rem_s;
  logic [Q-1:0]         div_q_s;

  // One restoring-division step, evaluated every cycle and used only in DIV.
  assign norm_done_s = dividend_q[mant_width] & divisor_q[mant_width];
  assign div_ge_s    = (rem_q >= {1'b0, divisor_q});
  assign div_diff_s  = div_ge_s ? (rem_q - {1'b0, divisor_q}) : rem_q;
  assign div_rem_s   = div_diff_s << 1;
  assign div_q_s     = {q_mant_q[Q-2:0], div_ge_s};

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_mant_q    <= '0;
      q_exp_q     <= '0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      bypass_q    <= 1'b0;
      direct_q    <= '0;
      flags_q     <= 6'b000000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      q_mant_q    <= q_mant_d;
      q_exp_q     <= q_exp_d;
      sticky_q    <= sticky_d;
      sign_q      <= sign_d;
      bypass_q    <= bypass_d;
      direct_q    <= direct_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    q_mant_d    = q_mant_q;
    q_exp_d     = q_exp_q;
    sticky_d    = sticky_q;
    sign_d      = sign_q;
    bypass_d    = bypass_q;
    direct_d    = direct_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = {hidA, mantA};
          divisor_d  = {hidB, mantB};
          exp_a_d    = exp_a;
          exp_b_d    = exp_b;
          sign_d     = sign;
          direct_d   = direct_result;
          flags_d    = {zero, inf, subN, Norm, QNan, SNan};
          bypass_d   = ~arithmetic;
          rem_d      = '0;
          cnt_d      = '0;
          q_mant_d   = '0;
          q_exp_d    = '0;
          sticky_d   = 1'b0;
          state_d    = arithmetic ? NORM : BYP;
        end else begin
          state_d = IDLE;
        end
      end
      BYP: begin
        state_d = DONE;
      end
      NORM: begin
        // The count bound only matters for a zero mantissa, which upstream never sends.
        if (norm_done_s || (cnt_q == CW'(mant_width))) begin
          q_exp_d = exp_a_q - exp_b_q;
          rem_d   = {1'b0, dividend_q};
          cnt_d   = '0;
          state_d = DIV;
        end else begin
          if (!dividend_q[mant_width]) begin
            dividend_d = dividend_q << 1;
            exp_a_d    = exp_a_q - EXP_ONE;
          end else begin
            dividend_d = dividend_q;
          end
          if (!divisor_q[mant_width]) begin
            divisor_d = divisor_q << 1;
            exp_b_d   = exp_b_q - EXP_ONE;
          end else begin
            divisor_d = divisor_q;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        rem_d    = div_rem_s;
        q_mant_d = div_q_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(Q - 1)) begin
          sticky_d = |div_rem_s;
          state_d  = DONE;
        end else begin
          state_d = DIV;
`ifdef DIV_EARLY_TERM_EN
          if (div_rem_s == '0) begin
            q_mant_d = div_q_s << (CW'(Q - 1) - cnt_q);
            sticky_d = 1'b0;
            state_d  = DONE;
          end else begin
            state_d = DIV;
          end
`else
          state_d = DIV;
`endif
        end
      end
      DONE: begin
        // Results land on entry; out_valid rises the following cycle.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_bypass = bypass_q;
  assign out_direct = direct_q;
  assign q_mant     = q_mant_q;
  assign q_exp      = q_exp_q;
  assign q_sign     = sign_q;
  assign sticky     = sticky_q;
  assign {out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan} = flags_q;

endmodule
